counter_monitor: RTL and testbench

//   Downstream checker for counter_example: consumes its eight 1-bit count outputs C0..C7,

---
 rtl/counter_monitor.sv | 137 +++++++++++++
 tb/tb_counter_monitor.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/counter_monitor.sv
// Step checker for an 8-bit counter presented as eight 1-bit inputs: confirms the value
// advances by +1 mod 256 (or optionally holds) and reports lock, mismatch and wrap events.
module counter_monitor #(
  parameter int unsigned LOCK_COUNT = 4,
  parameter bit          ALLOW_HOLD = 1'b1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        C0,
  input  logic        C1,
  input  logic        C2,
  input  logic        C3,
  input  logic        C4,
  input  logic        C5,
  input  logic        C6,
  input  logic        C7,
  output logic        LOCKED,
  output logic        MISMATCH,
  output logic        WRAP,
  output logic [7:0]  ERR_COUNT,
  output logic [15:0] WRAP_COUNT,
  output logic [7:0]  LAST
);

  typedef enum logic [1:0] {ST_SYNC, ST_ACQ, ST_LOCK} state_t;
  typedef enum logic [1:0] {CL_INC, CL_HOLD, CL_BAD} cls_t;

  localparam logic [3:0] LC = LOCK_COUNT[3:0];

  function automatic logic [7:0] sat_inc8(input logic [7:0] x);
    return (x == 8'hFF) ? x : x + 8'd1;
  endfunction

  logic [7:0]  w_v;
  logic        w_inc;
  logic        w_hold;
  logic        w_wrap_step;
  logic [3:0]  w_run_nxt;
  cls_t        w_cls;

  logic [7:0]  r_cur_p0;
  logic [7:0]  r_prev_p0;
  logic [1:0]  r_vcnt;
  state_t      r_state;
  logic [3:0]  r_run;
  logic        r_locked;
  logic        r_mismatch;
  logic        r_wrap;
  logic [7:0]  r_err_cnt;
  logic [15:0] r_wrap_cnt;

  assign w_v         = {C7, C6, C5, C4, C3, C2, C1, C0};
  assign w_inc       = (r_cur_p0 == r_prev_p0 + 8'd1);
  assign w_hold      = (r_cur_p0 == r_prev_p0);
  assign w_wrap_step = w_inc && (r_prev_p0 == 8'hFF);
  assign w_run_nxt   = r_run + 4'd1;

  // Unknown compare results fall through to CL_BAD, keeping X out of the FSM.
  always_comb begin
    w_cls = CL_BAD;
    if (w_inc)
      w_cls = CL_INC;
    else if (w_hold && ALLOW_HOLD)
      w_cls = CL_HOLD;
  end

  // Stage p0: capture and classification share the clock edge; all flags registered here.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_cur_p0   <= 8'h00;
      r_prev_p0  <= 8'h00;
      r_vcnt     <= 2'd0;
      r_state    <= ST_SYNC;
      r_run      <= 4'd0;
      r_locked   <= 1'b0;
      r_mismatch <= 1'b0;
      r_wrap     <= 1'b0;
      r_err_cnt  <= 8'h00;
      r_wrap_cnt <= 16'h0000;
    end else begin
      r_cur_p0   <= w_v;
      r_prev_p0  <= r_cur_p0;
      r_mismatch <= 1'b0;
      r_wrap     <= 1'b0;
      if (r_vcnt != 2'd2)
        r_vcnt <= r_vcnt + 2'd1;
      case (r_state)
        ST_SYNC: begin
          if (r_vcnt != 2'd0)
            r_state <= ST_ACQ;
        end
        ST_ACQ: begin
          case (w_cls)
            CL_INC: begin
              if (w_run_nxt == LC) begin
                r_state  <= ST_LOCK;
                r_locked <= 1'b1;
                r_run    <= 4'd0;
              end else begin
                r_run <= w_run_nxt;
              end
            end
            CL_HOLD: ;
            default: r_run <= 4'd0;
          endcase
        end
        ST_LOCK: begin
          case (w_cls)
            CL_INC: begin
              if (w_wrap_step) begin
                r_wrap     <= 1'b1;
                r_wrap_cnt <= r_wrap_cnt + 16'd1;
              end
            end
            CL_HOLD: ;
            default: begin
              r_mismatch <= 1'b1;
              r_err_cnt  <= sat_inc8(r_err_cnt);
              r_locked   <= 1'b0;
              r_run      <= 4'd0;
              r_state    <= ST_ACQ;
            end
          endcase
        end
        default: r_state <= ST_SYNC;
      endcase
    end
  end

  assign LOCKED     = r_locked;
  assign MISMATCH   = r_mismatch;
  assign WRAP       = r_wrap;
  assign ERR_COUNT  = r_err_cnt;
  assign WRAP_COUNT = r_wrap_cnt;
  assign LAST       = r_cur_p0;

endmodule

// File: tb/tb_counter_monitor.sv
// Bench for counter_monitor: three instances (hold legal, hold illegal, LOCK_COUNT=1) share
// one stimulus stream; expected outputs are queued at drive time and checked after each edge.
module tb_counter_monitor;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] v = 8'h00;

  always #5 CLK = ~CLK;

  logic        m_lk, m_mm, m_wr, h_lk, h_mm, h_wr, s_lk, s_mm, s_wr;
  logic [7:0]  m_err, h_err, s_err, m_last, h_last, s_last;
  logic [15:0] m_wc, h_wc, s_wc;

  counter_monitor #(.LOCK_COUNT(4), .ALLOW_HOLD(1'b1)) u_main (
    .CLK(CLK), .RESET(RESET),
    .C0(v[0]), .C1(v[1]), .C2(v[2]), .C3(v[3]), .C4(v[4]), .C5(v[5]), .C6(v[6]), .C7(v[7]),
    .LOCKED(m_lk), .MISMATCH(m_mm), .WRAP(m_wr),
    .ERR_COUNT(m_err), .WRAP_COUNT(m_wc), .LAST(m_last)
  );

  counter_monitor #(.LOCK_COUNT(4), .ALLOW_HOLD(1'b0)) u_hold0 (
    .CLK(CLK), .RESET(RESET),
    .C0(v[0]), .C1(v[1]), .C2(v[2]), .C3(v[3]), .C4(v[4]), .C5(v[5]), .C6(v[6]), .C7(v[7]),
    .LOCKED(h_lk), .MISMATCH(h_mm), .WRAP(h_wr),
    .ERR_COUNT(h_err), .WRAP_COUNT(h_wc), .LAST(h_last)
  );

  counter_monitor #(.LOCK_COUNT(1), .ALLOW_HOLD(1'b1)) u_sat (
    .CLK(CLK), .RESET(RESET),
    .C0(v[0]), .C1(v[1]), .C2(v[2]), .C3(v[3]), .C4(v[4]), .C5(v[5]), .C6(v[6]), .C7(v[7]),
    .LOCKED(s_lk), .MISMATCH(s_mm), .WRAP(s_wr),
    .ERR_COUNT(s_err), .WRAP_COUNT(s_wc), .LAST(s_last)
  );

  typedef struct {
    logic [1:0]  sel;
    logic        lk, mm, wr;
    logic [7:0]  err;
    logic [15:0] wc;
    logic [7:0]  last;
  } exp_t;

  typedef struct {
    logic       rst;
    logic [7:0] v;
    logic       lk, mm;
    logic [7:0] err;
    logic [7:0] last;
    logic       hlk, hmm;
    logic [7:0] herr;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic [7:0] val, input logic lk, input logic mm,
                     input logic [7:0] err, input logic [7:0] last,
                     input logic hlk, input logic hmm, input logic [7:0] herr);
    vec_t r;
    r.rst = rst; r.v = val; r.lk = lk; r.mm = mm; r.err = err; r.last = last;
    r.hlk = hlk; r.hmm = hmm; r.herr = herr;
    tbl.push_back(r);
  endtask

  task automatic push(input logic [1:0] sel, input logic lk, input logic mm, input logic wr,
                      input logic [7:0] err, input logic [15:0] wc, input logic [7:0] last);
    exp_t e;
    e.sel = sel; e.lk = lk; e.mm = mm; e.wr = wr; e.err = err; e.wc = wc; e.last = last;
    sbq.push_back(e);
  endtask

  task automatic drive(input logic rst, input logic [7:0] val);
    @(negedge CLK);
    RESET = rst;
    v     = val;
  endtask

  task automatic settle_check();
    exp_t e;
    @(posedge CLK);
    #1;
    cyc++;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      case (e.sel)
        2'd0: begin
          cmp("main.LOCKED", {15'd0, m_lk}, {15'd0, e.lk});
          cmp("main.MISMATCH", {15'd0, m_mm}, {15'd0, e.mm});
          cmp("main.WRAP", {15'd0, m_wr}, {15'd0, e.wr});
          cmp("main.ERR_COUNT", {8'd0, m_err}, {8'd0, e.err});
          cmp("main.WRAP_COUNT", m_wc, e.wc);
          cmp("main.LAST", {8'd0, m_last}, {8'd0, e.last});
        end
        2'd1: begin
          cmp("hold0.LOCKED", {15'd0, h_lk}, {15'd0, e.lk});
          cmp("hold0.MISMATCH", {15'd0, h_mm}, {15'd0, e.mm});
          cmp("hold0.WRAP", {15'd0, h_wr}, {15'd0, e.wr});
          cmp("hold0.ERR_COUNT", {8'd0, h_err}, {8'd0, e.err});
          cmp("hold0.WRAP_COUNT", h_wc, e.wc);
          cmp("hold0.LAST", {8'd0, h_last}, {8'd0, e.last});
        end
        default: begin
          cmp("sat.LOCKED", {15'd0, s_lk}, {15'd0, e.lk});
          cmp("sat.MISMATCH", {15'd0, s_mm}, {15'd0, e.mm});
          cmp("sat.WRAP", {15'd0, s_wr}, {15'd0, e.wr});
          cmp("sat.ERR_COUNT", {8'd0, s_err}, {8'd0, e.err});
          cmp("sat.WRAP_COUNT", s_wc, e.wc);
          cmp("sat.LAST", {8'd0, s_last}, {8'd0, e.last});
        end
      endcase
    end
  endtask

  initial begin
    logic [7:0] x;
    logic [15:0] wcnt;
    int mcnt;

    // Reset (with junk on the bus), then lock on 0,1,2,...: LOCKED after 6th low edge.
    add(1, 8'hAA, 0, 0, 0, 8'h00, 0, 0, 0);
    add(1, 8'hAA, 0, 0, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i <= 4; i++)
      add(0, 8'(i), 0, 0, 0, 8'(i), 0, 0, 0);
    add(0, 8'h05, 1, 0, 0, 8'h05, 1, 0, 0);
    for (int i = 6; i <= 'h3F; i++)
      add(0, 8'(i), 1, 0, 0, 8'(i), 1, 0, 0);
    // Glitch 3F,55,41,42..: one MISMATCH, relock after four INC steps from 41.
    add(0, 8'h55, 1, 0, 0, 8'h55, 1, 0, 0);
    add(0, 8'h41, 0, 1, 1, 8'h41, 0, 1, 1);
    add(0, 8'h42, 0, 0, 1, 8'h42, 0, 0, 1);
    add(0, 8'h43, 0, 0, 1, 8'h43, 0, 0, 1);
    add(0, 8'h44, 0, 0, 1, 8'h44, 0, 0, 1);
    add(0, 8'h45, 0, 0, 1, 8'h45, 0, 0, 1);
    add(0, 8'h46, 1, 0, 1, 8'h46, 1, 0, 1);
    add(0, 8'h47, 1, 0, 1, 8'h47, 1, 0, 1);
    // Value 48 held for three cycles: legal for main, BAD for hold0.
    add(0, 8'h48, 1, 0, 1, 8'h48, 1, 0, 1);
    add(0, 8'h48, 1, 0, 1, 8'h48, 1, 0, 1);
    add(0, 8'h48, 1, 0, 1, 8'h48, 0, 1, 2);
    add(0, 8'h49, 1, 0, 1, 8'h49, 0, 0, 2);
    add(0, 8'h4A, 1, 0, 1, 8'h4A, 0, 0, 2);
    add(0, 8'h4B, 1, 0, 1, 8'h4B, 0, 0, 2);
    add(0, 8'h4C, 1, 0, 1, 8'h4C, 0, 0, 2);
    add(0, 8'h4D, 1, 0, 1, 8'h4D, 1, 0, 2);
    // Second glitch brings main ERR_COUNT to 2, then relock.
    add(0, 8'h70, 1, 0, 1, 8'h70, 1, 0, 2);
    add(0, 8'h71, 0, 1, 2, 8'h71, 0, 1, 3);
    add(0, 8'h72, 0, 0, 2, 8'h72, 0, 0, 3);
    add(0, 8'h73, 0, 0, 2, 8'h73, 0, 0, 3);
    add(0, 8'h74, 0, 0, 2, 8'h74, 0, 0, 3);
    add(0, 8'h75, 1, 0, 2, 8'h75, 1, 0, 3);
    // Reset mid-operation for one edge, then relock from zero.
    add(1, 8'h76, 0, 0, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i <= 4; i++)
      add(0, 8'(i), 0, 0, 0, 8'(i), 0, 0, 0);
    add(0, 8'h05, 1, 0, 0, 8'h05, 1, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].v);
      push(2'd0, tbl[i].lk, tbl[i].mm, 1'b0, tbl[i].err, 16'd0, tbl[i].last);
      push(2'd1, tbl[i].hlk, tbl[i].hmm, 1'b0, tbl[i].herr, 16'd0, tbl[i].last);
      settle_check();
    end

    // Free-running counter for 1000 cycles: WRAP at each FF->00 step, three in total.
    wcnt = 16'd0;
    for (int i = 6; i <= 1005; i++) begin
      logic w;
      w = ((i % 256) == 1) && (i > 256);
      if (w) wcnt = wcnt + 16'd1;
      drive(1'b0, 8'(i));
      push(2'd0, 1'b1, 1'b0, w, 8'd0, wcnt, 8'(i));
      settle_check();
    end
    cmp("wrap.final_WRAP_COUNT", m_wc, 16'd3);

    // Saturation with LOCK_COUNT=1: alternating INC (+1) and BAD (+11) steps, 600 steps.
    drive(1'b1, 8'h00);
    push(2'd2, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0, 8'h00);
    push(2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0, 8'h00);
    settle_check();
    x = 8'h00;
    mcnt = 0;
    for (int k = 0; k <= 601; k++) begin
      drive(1'b0, x);
      if (k < 2) begin
        push(2'd2, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0, x);
      end else if (((k - 2) % 2) == 0) begin
        push(2'd2, 1'b1, 1'b0, 1'b0, 8'((mcnt > 255) ? 255 : mcnt), 16'd0, x);
      end else begin
        mcnt++;
        push(2'd2, 1'b0, 1'b1, 1'b0, 8'((mcnt > 255) ? 255 : mcnt), 16'd0, x);
      end
      settle_check();
      x = ((k % 2) == 0) ? x + 8'h01 : x + 8'h11;
    end
    cmp("sat.final_ERR_COUNT", {8'd0, s_err}, 16'd255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
